// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with start/done handshake.
// One multiplier bit is consumed per cycle; signed operation is done on
// magnitudes with the sign restored in a final FIX cycle.
module seq_mult_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  mag_a_q, mag_a_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [PW-1:0]     partial;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which
  // still fits because the magnitude is treated as unsigned.
  always_comb begin
    abs_a = (signed_mode && a_in[WIDTH-1]) ? (~a_in) + WIDTH'(1) : a_in;
    abs_b = (signed_mode && b_in[WIDTH-1]) ? (~b_in) + WIDTH'(1) : b_in;
    partial = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;
  end

  // Next-state and datapath updates for IDLE / RUN / FIX.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_a_d = abs_a;
          mag_b_d = abs_b;
          neg_d   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (mag_b_q[cnt_q]) acc_d = acc_q + partial;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        // Negating zero yields zero, so neg with a zero magnitude is harmless.
        product_d = neg_q ? (~acc_q) + PW'(1) : acc_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param at WIDTH = 4, 16 and 32.
// The driver predicts acceptance and completion of each start and queues the
// expected product with its completion cycle; a monitor compares every cycle.
module tb_seq_mult_param;

  typedef struct {
    int          inst;
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = '0;
  logic        smode = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [63:0] prod [3];

  int          wv [3] = '{4, 16, 32};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb [$];
  int          acc_edge [3];
  int          free_edge [3];
  logic [63:0] last_prod [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 4 : (g == 1) ? 16 : 32;
    logic [2*W-1:0] p;
    seq_mult_param #(.WIDTH(W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .signed_mode(smode),
      .a_in       (a_in[W-1:0]),
      .b_in       (b_in[W-1:0]),
      .busy       (busy[g]),
      .done       (done[g]),
      .product    (p)
    );
    assign prod[g] = 64'(p);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference product: plain integer multiplication of the operands as read
  // at width w, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(int w, bit s, logic [31:0] a, logic [31:0] b);
    logic [63:0] ua, ub, m, r;
    longint      sa, sbv;
    ua = 64'(a) & ((64'd1 << w) - 64'd1);
    ub = 64'(b) & ((64'd1 << w) - 64'd1);
    if (s) begin
      sa  = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
      sbv = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
      r   = 64'(sa * sbv);
    end else begin
      r = ua * ub;
    end
    m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return r & m;
  endfunction

  // One cycle with start raised on instance g; the model accepts it only if
  // that instance is idle at the sampling edge.
  task automatic drive(input int g, input bit s, input logic [31:0] a, input logic [31:0] b);
    int e;
    @(negedge clk);
    start    = '0;
    start[g] = 1'b1;
    smode    = s;
    a_in     = a;
    b_in     = b;
    e = cyc + 1;
    if (e >= free_edge[g]) begin
      acc_edge[g]  = e;
      free_edge[g] = e + wv[g] + 2;
      sb.push_back('{g, ref_mul(wv[g], s, a, b), e + wv[g] + 1});
    end
  endtask

  // Idle cycles with scrambled operand buses to show operands were captured.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = '0;
      smode = 1'($urandom);
      a_in  = $urandom;
      b_in  = $urandom;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = '0;
    rst   = 1'b1;
    sb.delete();
    for (int g = 0; g < 3; g++) begin
      free_edge[g] = cyc + 2;
      acc_edge[g]  = -1000;
      last_prod[g] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: busy every cycle, product/done timing against the scoreboard.
  always @(posedge clk) begin : mon
    int qi [$];
    #1;
    if (cyc >= 1) begin
      for (int g = 0; g < 3; g++) begin
        check($sformatf("busy%0d", g), 64'(busy[g]),
              64'((cyc >= acc_edge[g]) && (cyc <= acc_edge[g] + wv[g])));
        qi = sb.find_first_index(item) with (item.inst == g);
        if (done[g]) begin
          if (qi.size() == 0) begin
            check($sformatf("done%0d_unexpected", g), 64'(done[g]), 64'(0));
          end else begin
            check($sformatf("done%0d_cycle", g), 64'(cyc), 64'(sb[qi[0]].cyc));
            check($sformatf("product%0d", g), prod[g], sb[qi[0]].prod);
            last_prod[g] = sb[qi[0]].prod;
            sb.delete(qi[0]);
          end
        end else begin
          if (qi.size() != 0 && sb[qi[0]].cyc <= cyc) begin
            check($sformatf("done%0d_missing", g), 64'(done[g]), 64'(1));
            sb.delete(qi[0]);
          end
          check($sformatf("hold%0d", g), prod[g], last_prod[g]);
        end
      end
    end
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      acc_edge[g]  = -1000;
      free_edge[g] = 0;
      last_prod[g] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) free_edge[g] = cyc + 1;

    // WIDTH=16 directed cases
    drive(1, 0, 32'd3, 32'd5);           idle(20);
    drive(1, 0, 32'hFFFF, 32'hFFFF);     idle(20);
    drive(1, 0, 32'h0, 32'h1234);        idle(20);
    drive(1, 1, 32'hFFFD, 32'h0005);     idle(20);
    drive(1, 1, 32'h8000, 32'h8000);     idle(20);
    drive(1, 1, 32'h8000, 32'h0001);     idle(20);
    drive(1, 1, 32'h7FFF, 32'hFFFF);     idle(20);
    drive(1, 1, 32'h0000, 32'hFFFF);     idle(20);

    // Start while busy is ignored
    drive(1, 0, 32'd2, 32'd3);           idle(3);
    drive(1, 0, 32'd7, 32'd7);           idle(20);

    // Start held high: back-to-back operations, product held between pulses
    for (int i = 0; i < 60; i++) drive(1, 0, 32'd4, 32'd4);
    idle(20);

    // Reset mid-operation: no done afterwards, then a clean operation
    drive(1, 0, 32'd100, 32'd100);       idle(6);
    do_reset();                          idle(25);
    drive(1, 0, 32'd10, 32'd10);         idle(20);

    // WIDTH=4 and WIDTH=32 corners
    drive(0, 0, 32'hF, 32'hF);           idle(8);
    drive(0, 1, 32'h8, 32'h8);           idle(8);
    drive(0, 1, 32'h8, 32'h7);           idle(8);
    drive(2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(36);
    drive(2, 1, 32'h8000_0000, 32'h8000_0000); idle(36);
    drive(2, 1, 32'hFFFF_FFFD, 32'h0000_0005); idle(36);

    // Randomised traffic across all widths, including starts that hit busy
    for (int i = 0; i < 150; i++) begin
      drive($urandom_range(0, 2), 1'($urandom), $urandom, $urandom);
      idle($urandom_range(0, 40));
    end

    idle(40);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
